// File: rtl/instr_decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode_stage_if
//  Description : Instruction, decoded-output, writeback and scoreboard
//                signals of the decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_decode_stage_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  opcode;
    logic [3:0]  dest;
    logic [3:0]  srcadd1;
    logic [3:0]  srcadd2;
    logic [31:0] imm;
    logic        wb_valid;
    logic [3:0]  wb_dest;
    logic [15:0] pending;
    logic [15:0] stall_cnt;

    modport master (
        output instr, instr_valid, out_ready, wb_valid, wb_dest,
        input  instr_ready, out_valid, opcode, dest, srcadd1, srcadd2, imm,
               pending, stall_cnt
    );

    modport slave (
        input  instr, instr_valid, out_ready, wb_valid, wb_dest,
        output instr_ready, out_valid, opcode, dest, srcadd1, srcadd2, imm,
               pending, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/instr_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode_stage
//  Description : Single-register decode stage with a pending-write
//                scoreboard that stalls RAW/WAW hazards, plus a saturating
//                stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decode_stage #(
    parameter bit         IMM_SEXT    = 1'b1,
    parameter bit         HAZARD_EN   = 1'b1,
    parameter logic [3:0] NOWB_OPCODE = 4'b1111
) (
    input  logic                  clk,
    input  logic                  reset_n,
    instr_decode_stage_if.slave   bus
);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [3:0]  r_opcode;
    logic [3:0]  r_dest;
    logic [3:0]  r_src1;
    logic [3:0]  r_src2;
    logic [31:0] r_imm;
    logic [15:0] r_pending;
    logic [15:0] r_stall_cnt;

    logic [3:0]  w_op;
    logic [3:0]  w_dst;
    logic [3:0]  w_s1;
    logic [3:0]  w_s2;
    logic [31:0] w_imm_ext;
    logic        w_writes;
    logic [15:0] w_clr_mask;
    logic [15:0] w_set_mask;
    logic [15:0] w_eff;
    logic        w_hazard;
    logic        w_ready;
    logic        w_accept;

    assign w_op  = bus.instr[31:28];
    assign w_dst = bus.instr[27:24];
    assign w_s1  = bus.instr[23:20];
    assign w_s2  = bus.instr[19:16];

    generate
        if (IMM_SEXT) begin : g_sext
            assign w_imm_ext = {{16{bus.instr[15]}}, bus.instr[15:0]};
        end else begin : g_zext
            assign w_imm_ext = {16'h0000, bus.instr[15:0]};
        end
    endgenerate

    // Writeback clears its bit before the hazard check so a retiring
    // register unblocks the dependent instruction in the same cycle.
    assign w_writes   = (w_op != NOWB_OPCODE);
    assign w_clr_mask = bus.wb_valid ? (16'h0001 << bus.wb_dest) : 16'h0000;
    assign w_eff      = r_pending & ~w_clr_mask;
    assign w_hazard   = HAZARD_EN &&
                        (w_eff[w_s1] || w_eff[w_s2] || (w_writes && w_eff[w_dst]));

    assign w_ready    = reset_n && !w_hazard && ((r_state == S_EMPTY) || bus.out_ready);
    assign w_accept   = bus.instr_valid && w_ready;
    assign w_set_mask = (w_accept && w_writes) ? (16'h0001 << w_dst) : 16'h0000;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
            S_FULL:  if (bus.out_ready && !w_accept) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_opcode <= 4'h0;
            r_dest   <= 4'h0;
            r_src1   <= 4'h0;
            r_src2   <= 4'h0;
            r_imm    <= 32'h0000_0000;
        end else if (w_accept) begin
            r_opcode <= w_op;
            r_dest   <= w_dst;
            r_src1   <= w_s1;
            r_src2   <= w_s2;
            r_imm    <= w_imm_ext;
        end
    end

    // OR-ing the set mask last lets a same-cycle issue win over writeback.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= 16'h0000;
        end else begin
            r_pending <= w_eff | w_set_mask;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= 16'h0000;
        end else if (bus.instr_valid && w_hazard && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign bus.instr_ready = w_ready;
    assign bus.out_valid   = (r_state == S_FULL);
    assign bus.opcode      = r_opcode;
    assign bus.dest        = r_dest;
    assign bus.srcadd1     = r_src1;
    assign bus.srcadd2     = r_src2;
    assign bus.imm         = r_imm;
    assign bus.pending     = r_pending;
    assign bus.stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_decode_stage
//  Description : Directed, table-driven bench for instr_decode_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_decode_stage;

    logic clk;
    logic reset_n;

    instr_decode_stage_if bus ();

    instr_decode_stage dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        vld;
        logic        ordy;
        logic        wbv;
        logic [3:0]  wbd;
        logic        e_rdy;
        logic        e_ov;
        logic [3:0]  e_op;
        logic [3:0]  e_dst;
        logic [3:0]  e_s1;
        logic [3:0]  e_s2;
        logic [31:0] e_imm;
        logic [15:0] e_pnd;
        logic [15:0] e_stall;
    } vec_t;

    vec_t vecs [11];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic [3:0] op,
                           input logic [3:0] dst, input logic [3:0] s1, input logic [3:0] s2,
                           input logic [31:0] imm, input logic [15:0] pnd, input logic [15:0] st);
        chk({tag, ".out_valid"}, {31'b0, bus.out_valid}, {31'b0, ov});
        chk({tag, ".opcode"},    {28'b0, bus.opcode},    {28'b0, op});
        chk({tag, ".dest"},      {28'b0, bus.dest},      {28'b0, dst});
        chk({tag, ".srcadd1"},   {28'b0, bus.srcadd1},   {28'b0, s1});
        chk({tag, ".srcadd2"},   {28'b0, bus.srcadd2},   {28'b0, s2});
        chk({tag, ".imm"},       bus.imm,                imm);
        chk({tag, ".pending"},   {16'b0, bus.pending},   {16'b0, pnd});
        chk({tag, ".stall_cnt"}, {16'b0, bus.stall_cnt}, {16'b0, st});
    endtask

    task automatic drive(input logic [31:0] ins, input logic vld, input logic ordy,
                         input logic wbv, input logic [3:0] wbd);
        @(negedge clk);
        bus.instr       = ins;
        bus.instr_valid = vld;
        bus.out_ready   = ordy;
        bus.wb_valid    = wbv;
        bus.wb_dest     = wbd;
        #1;
    endtask

    task automatic chk_rdy(input string tag, input logic exp);
        chk({tag, ".instr_ready"}, {31'b0, bus.instr_ready}, {31'b0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // instr, vld, ordy, wbv, wbd | rdy, ov, op, dst, s1, s2, imm, pending, stall
        vecs[0]  = '{32'h1321_FFFE, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'h1, 4'h3, 4'h2, 4'h1, 32'hFFFF_FFFE, 16'h0008, 16'd0};
        vecs[1]  = '{32'h2456_0010, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'h2, 4'h4, 4'h5, 4'h6, 32'h0000_0010, 16'h0018, 16'd0};
        vecs[2]  = '{32'hF500_8000, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'hF, 4'h5, 4'h0, 4'h0, 32'hFFFF_8000, 16'h0018, 16'd0};
        vecs[3]  = '{32'h7655_1234, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'h7, 4'h6, 4'h5, 4'h5, 32'h0000_1234, 16'h0058, 16'd0};
        vecs[4]  = '{32'h8730_0001, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h7, 4'h6, 4'h5, 4'h5, 32'h0000_1234, 16'h0058, 16'd1};
        vecs[5]  = '{32'h8730_0001, 1'b1, 1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 4'h8, 4'h7, 4'h3, 4'h0, 32'h0000_0001, 16'h00D0, 16'd1};
        vecs[6]  = '{32'h9400_0000, 1'b1, 1'b1, 1'b1, 4'h4, 1'b1, 1'b1, 4'h9, 4'h4, 4'h0, 4'h0, 32'h0000_0000, 16'h00D0, 16'd1};
        vecs[7]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 4'hA, 1'b1, 1'b0, 4'h9, 4'h4, 4'h0, 4'h0, 32'h0000_0000, 16'h00D0, 16'd1};
        vecs[8]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 4'h7, 1'b1, 1'b0, 4'h9, 4'h4, 4'h0, 4'h0, 32'h0000_0000, 16'h0050, 16'd1};
        vecs[9]  = '{32'hA600_0000, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h9, 4'h4, 4'h0, 4'h0, 32'h0000_0000, 16'h0050, 16'd2};
        vecs[10] = '{32'hA600_0000, 1'b1, 1'b1, 1'b1, 4'h6, 1'b1, 1'b1, 4'hA, 4'h6, 4'h0, 4'h0, 32'h0000_0000, 16'h0050, 16'd2};

        reset_n         = 1'b0;
        bus.instr       = 32'h0;
        bus.instr_valid = 1'b0;
        bus.out_ready   = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_dest     = 4'h0;
        step();
        step();
        chk_rdy("reset", 1'b0);
        chk_out("reset", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 16'h0, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].instr, vecs[i].vld, vecs[i].ordy, vecs[i].wbv, vecs[i].wbd);
            chk_rdy($sformatf("vec%0d", i), vecs[i].e_rdy);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_op, vecs[i].e_dst,
                    vecs[i].e_s1, vecs[i].e_s2, vecs[i].e_imm, vecs[i].e_pnd, vecs[i].e_stall);
        end

        // Backpressure: outputs frozen while out_ready=0, then back-to-back accepts.
        for (int c = 0; c < 3; c++) begin
            drive(32'hB100_0002, 1'b1, 1'b0, 1'b0, 4'h0);
            chk_rdy($sformatf("bp%0d", c), 1'b0);
            step();
            chk_out($sformatf("bp%0d", c), 1'b1, 4'hA, 4'h6, 4'h0, 4'h0, 32'h0, 16'h0050, 16'd2);
        end
        drive(32'hB100_0002, 1'b1, 1'b1, 1'b0, 4'h0);
        chk_rdy("b2b0", 1'b1);
        step();
        chk_out("b2b0", 1'b1, 4'hB, 4'h1, 4'h0, 4'h0, 32'h2, 16'h0052, 16'd2);
        drive(32'hC200_0003, 1'b1, 1'b1, 1'b0, 4'h0);
        chk_rdy("b2b1", 1'b1);
        step();
        chk_out("b2b1", 1'b1, 4'hC, 4'h2, 4'h0, 4'h0, 32'h3, 16'h0056, 16'd2);
        drive(32'h0000_0000, 1'b0, 1'b1, 1'b0, 4'h0);
        step();
        chk_out("drain", 1'b0, 4'hC, 4'h2, 4'h0, 4'h0, 32'h3, 16'h0056, 16'd2);

        // RAW on r1 held for several cycles, released by same-cycle writeback.
        for (int c = 0; c < 4; c++) begin
            drive(32'hD010_0000, 1'b1, 1'b1, 1'b0, 4'h0);
            chk_rdy($sformatf("raw%0d", c), 1'b0);
            step();
            chk({$sformatf("raw%0d", c), ".stall_cnt"}, {16'b0, bus.stall_cnt}, 32'd3 + 32'(c));
        end
        drive(32'hD010_0000, 1'b1, 1'b1, 1'b1, 4'h1);
        chk_rdy("rawwb", 1'b1);
        step();
        chk_out("rawwb", 1'b1, 4'hD, 4'h0, 4'h1, 4'h0, 32'h0, 16'h0055, 16'd6);

        // Asynchronous reset mid-cycle with an instruction in flight.
        drive(32'hE300_0000, 1'b1, 1'b1, 1'b0, 4'h0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_rdy("arst", 1'b0);
        chk_out("arst", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 16'h0, 16'd0);
        @(negedge clk);
        reset_n         = 1'b1;
        bus.instr_valid = 1'b0;
        step();
        chk_out("postrst", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 16'h0, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
